// File: rtl/riscv_pkg.sv
// RV32 load/store funct3 encodings, LSU state type and funct3 legality/alignment helpers.
// Shared by the load/store unit and its lane formatter; no logic of its own.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatter: store strobes/replicated data, load lane extraction with sign/zero extension.
// Latency: combinational. Backpressure: none, a pure function of its inputs.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (st_funct3)
            F3_B: begin
                st_wstrb = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_wstrb = 4'b0011 << {st_lane[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            F3_W: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shifted = ld_word >> {ld_lane, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = ld_word;
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store responder: one access per instruction over a req/ack bus, pipeline stalled until done.
// Latency: accept -> REQ next cycle -> DONE the cycle after ack; stall holds ex_* from accept through REQ.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memwrite,
    input  logic        ex_memread,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           is_load_q;
    logic [2:0]     ld_funct3_q;
    logic [1:0]     ld_lane_q;
    logic [31:0]    rdata_q;
    logic           rdata_valid_q;
    logic           misaligned_q;
    logic           bus_err_q;
    logic           mem_req_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [3:0]     mem_wstrb_q;
    logic [31:0]    mem_wdata_q;

    logic           op;
    logic           legal;
    logic           mis;
    logic           accept;
    logic [3:0]     st_wstrb;
    logic [31:0]    st_wdata;
    logic [31:0]    ld_data;

    // A store wins when the decoder flags both read and write.
    assign op     = ex_valid && (ex_memread || ex_memwrite);
    assign legal  = f3_legal(ex_memwrite, ex_funct3);
    assign mis    = f3_misaligned(ex_funct3, ex_addr[1:0]);
    assign accept = op && legal && !mis;
    assign stall  = (state_q == REQ) || ((state_q == IDLE) && accept);

    lsu_align u_align (
        .st_funct3 (ex_funct3),
        .st_lane   (ex_addr[1:0]),
        .st_data   (ex_wdata),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .ld_funct3 (ld_funct3_q),
        .ld_lane   (ld_lane_q),
        .ld_word   (mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_load_q     <= 1'b0;
            ld_funct3_q   <= 3'b000;
            ld_lane_q     <= 2'b00;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wstrb_q   <= 4'b0000;
            mem_wdata_q   <= 32'h0;
        end else begin
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op && !legal) begin
                        bus_err_q <= 1'b1;
                    end else if (op && mis) begin
                        misaligned_q <= 1'b1;
                    end else if (accept) begin
                        state_q     <= REQ;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ex_memwrite;
                        mem_addr_q  <= {ex_addr[31:2], 2'b00};
                        mem_wstrb_q <= ex_memwrite ? st_wstrb : 4'b0000;
                        mem_wdata_q <= ex_memwrite ? st_wdata : 32'h0;
                        is_load_q   <= !ex_memwrite;
                        ld_funct3_q <= ex_funct3;
                        ld_lane_q   <= ex_addr[1:0];
                    end
                end
                REQ: begin
                    // An ack in the final counted cycle still completes normally.
                    if (mem_ack || (cnt_q == CNT_LAST)) begin
                        state_q     <= DONE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wstrb_q <= 4'b0000;
                        mem_wdata_q <= 32'h0;
                        if (mem_ack) begin
                            bus_err_q     <= mem_err;
                            rdata_valid_q <= is_load_q && !mem_err;
                            rdata_q       <= (is_load_q && !mem_err) ? ld_data : 32'h0;
                        end else begin
                            bus_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign misaligned  = misaligned_q;
    assign bus_err     = bus_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
